// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the N x N PE accumulators after a fixed
// compute latency, streams them row-major, then pulses an accumulator clear.
module systolic_result_drain #(
    parameter int N              = 3,
    parameter int DW             = 16,
    parameter int COMPUTE_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N*N*DW-1:0]    result_in,
    output logic                 busy,
    output logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_data,
    output logic [$clog2(N)-1:0] out_row,
    output logic [$clog2(N)-1:0] out_col,
    output logic                 out_last
);

    localparam int RW = $clog2(N);
    localparam int IW = $clog2(N*N);
    localparam int CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    localparam logic [IW-1:0] LAST = IW'(N*N-1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [RW-1:0]     row_q, row_d;
    logic [RW-1:0]     col_q, col_d;
    logic [N*N*DW-1:0] snap_q, snap_d;
    logic [DW-1:0]     data_q, data_d;
    logic              last_q, last_d;
    logic              valid_q, busy_q, clr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        snap_d  = snap_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(COMPUTE_CYCLES-1);
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    snap_d  = result_in;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DRAIN: begin
                // out_valid is high throughout DRAIN, so ready alone is the handshake
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        state_d = S_CLEAR;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == RW'(N-1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        data_d = '0;
        last_d = 1'b0;
        if (state_d == S_DRAIN) begin
            data_d = snap_d[int'(idx_d)*DW +: DW];
            last_d = (idx_d == LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            snap_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= (state_d == S_DRAIN);
            busy_q  <= (state_d != S_IDLE);
            clr_q   <= (state_d == S_CLEAR);
        end
    end

    assign busy      = busy_q;
    assign acc_clr   = clr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;

endmodule
